// File: rtl/cpu_clk_pkg.sv
// cpu_clk_pkg: state encoding and default debounce length for the CPU clock controller
package cpu_clk_pkg;
   localparam logic [1:0] ST_HALT = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_STEP = 2'd2;
   localparam logic [1:0] ST_BRK  = 2'd3;
   localparam int DEB_CYCLES_DEF = 1000000;
   typedef enum logic [1:0] {
      S_HALT = ST_HALT,
      S_RUN  = ST_RUN,
      S_STEP = ST_STEP,
      S_BRK  = ST_BRK
   } state_t;
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: sync2 plus counter debounce of an asynchronous level, with rising-edge pulse
module btn_debounce
   import cpu_clk_pkg::*;
#(
   parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic dout,
   output logic rise
);
   localparam int W = $clog2(DEB_CYCLES + 1);
   localparam logic [W-1:0] LAST = W'(DEB_CYCLES - 1);
   logic s1, s2;
   logic [W-1:0] cnt;
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         s1   <= 1'b0;
         s2   <= 1'b0;
         cnt  <= '0;
         dout <= 1'b0;
         rise <= 1'b0;
      end else begin
         s1   <= din;
         s2   <= s1;
         rise <= 1'b0;
         if (s2 == dout) cnt <= '0;
         else if (cnt == LAST) begin
            cnt  <= '0;
            dout <= s2;
            rise <= s2;
         end else cnt <= cnt + W'(1);
      end
endmodule

// File: rtl/cpu_clk_ctrl.sv
// cpu_clk_ctrl: run/halt/step gating of clk_sys ticks into cpu_ce; CPU_CLK_CYCLE_COUNT_EN enables cycle_cnt
module cpu_clk_ctrl
   import cpu_clk_pkg::*;
#(
   parameter int DEB_CYCLES = DEB_CYCLES_DEF,
   parameter int CNT_W      = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clk_sys,
   input  logic             sw_run,
   input  logic             btn_step,
   input  logic             halt_req,
   output logic             cpu_ce,
   output logic             running,
   output logic             halted,
   output logic [CNT_W-1:0] cycle_cnt
);
   logic cs_q, tick, run_db, step_pe, run_rise_unused, step_lvl_unused, ce_nxt;
   state_t state, nxt;
   btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_run (
      .clk(clk), .rst(rst), .din(sw_run), .dout(run_db), .rise(run_rise_unused)
   );
   btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_step (
      .clk(clk), .rst(rst), .din(btn_step), .dout(step_lvl_unused), .rise(step_pe)
   );
   assign tick = clk_sys & ~cs_q;
   // halt_req always wins over a tick arriving in the same cycle
   always_comb begin
      nxt    = state;
      ce_nxt = 1'b0;
      unique case (state)
         S_HALT: nxt = run_db ? S_RUN : step_pe ? S_STEP : S_HALT;
         S_STEP: begin
            nxt    = (halt_req || tick) ? S_HALT : S_STEP;
            ce_nxt = tick & ~halt_req;
         end
         S_RUN: begin
            nxt    = halt_req ? S_BRK : !run_db ? S_HALT : S_RUN;
            ce_nxt = tick & ~halt_req & run_db;
         end
         S_BRK:  nxt = run_db ? S_BRK : S_HALT;
      endcase
   end
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state   <= S_HALT;
         cs_q    <= 1'b0;
         cpu_ce  <= 1'b0;
         running <= 1'b0;
         halted  <= 1'b1;
      end else begin
         state   <= nxt;
         cs_q    <= clk_sys;
         cpu_ce  <= ce_nxt;
         running <= (nxt == S_RUN);
         halted  <= (nxt == S_HALT) || (nxt == S_BRK);
      end
`ifdef CPU_CLK_CYCLE_COUNT_EN
   always_ff @(posedge clk or negedge rst)
      if (!rst) cycle_cnt <= '0;
      else if (ce_nxt) cycle_cnt <= cycle_cnt + CNT_W'(1);
`else
   assign cycle_cnt = '0;
`endif
endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// tb_cpu_clk_ctrl: directed checks of run/halt/step/break gating with DEB_CYCLES=4, clk_sys=clk/6
module tb_cpu_clk_ctrl;
   logic clk = 1'b0, rst = 1'b0, sw_run = 1'b0, btn_step = 1'b0, halt_req = 1'b0;
   logic [2:0] div = 3'd0;
   logic clk_sys, cpu_ce, running, halted;
   logic [31:0] cycle_cnt;
   int n_chk = 0, n_err = 0;
   int c, o, c2, o2;
   always #5 clk = ~clk;
   always @(posedge clk) div <= (div == 3'd5) ? 3'd0 : div + 3'd1;
   // high for div 0..2, so the DUT tick falls in the div==0 cycle and cpu_ce in div==1
   assign clk_sys = (div < 3'd3);
   cpu_clk_ctrl #(.DEB_CYCLES(4), .CNT_W(32)) dut (
      .clk(clk), .rst(rst), .clk_sys(clk_sys), .sw_run(sw_run), .btn_step(btn_step),
      .halt_req(halt_req), .cpu_ce(cpu_ce), .running(running), .halted(halted),
      .cycle_cnt(cycle_cnt)
   );
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask
   function automatic logic [63:0] cexp(input int n);
`ifdef CPU_CLK_CYCLE_COUNT_EN
      return 64'(n);
`else
      return 64'(n - n);
`endif
   endfunction
   task automatic tick_n(input int n);
      repeat (n) @(negedge clk);
   endtask
   task automatic count_ce(input int n, output int ces, output int off);
      ces = 0;
      off = 0;
      repeat (n) begin
         @(negedge clk);
         if (cpu_ce) begin
            ces++;
            if (div != 3'd1) off++;
         end
      end
   endtask
   task automatic wait_div(input logic [2:0] d);
      do @(negedge clk); while (div != d);
   endtask
   task automatic wait_sig(input string tag, input int sel, input logic want, input int bound);
      logic v;
      v = ~want;
      for (int i = 0; i < bound && v != want; i++) begin
         @(negedge clk);
         v = sel ? halted : running;
      end
      check(tag, v, want);
   endtask
   task automatic press(input int len);
      wait_div(3'd1);
      btn_step = 1'b1;
      tick_n(len);
      btn_step = 1'b0;
   endtask
   task automatic do_reset;
      rst = 1'b0;
      tick_n(3);
      rst = 1'b1;
      tick_n(2);
   endtask
   initial begin
      tick_n(3);
      rst = 1'b1;
      count_ce(100, c, o);
      check("idle_ce", c, 0);
      check("idle_halted", halted, 1);
      check("idle_running", running, 0);
      check("idle_cnt", cycle_cnt, 0);
      sw_run = 1'b1;
      tick_n(5);
      check("run_debouncing", running, 0);
      wait_sig("run_entered", 0, 1'b1, 10);
      c = 0;
      o = 0;
      for (int i = 0; i < 100 && c < 10; i++) begin
         @(negedge clk);
         if (cpu_ce) begin
            c++;
            if (div != 3'd1) o++;
         end
      end
      check("run_ce_count", c, 10);
      check("run_ce_phase", o, 0);
      tick_n(1);
      check("run_cnt10", cycle_cnt, cexp(10));
      press(10);
      count_ce(60, c, o);
      check("run_step_ignored", c, 10);
      check("run_still", running, 1);
      wait_div(3'd0);
      halt_req = 1'b1;
      @(negedge clk);
      halt_req = 1'b0;
      check("brk_no_ce", cpu_ce, 0);
      check("brk_halted", halted, 1);
      check("brk_running", running, 0);
      count_ce(30, c, o);
      check("brk_hold_run", c, 0);
      sw_run = 1'b0;
      tick_n(10);
      check("brk_to_halt", halted, 1);
      sw_run = 1'b1;
      wait_sig("resume_running", 0, 1'b1, 12);
      count_ce(30, c, o);
      check("resume_ce", c, 5);
      check("resume_phase", o, 0);
      sw_run = 1'b0;
      wait_sig("stop_halted", 1, 1'b1, 12);
      do_reset;
      press(10);
      count_ce(30, c, o);
      check("step1_ce", c, 1);
      check("step1_phase", o, 0);
      check("step1_halted", halted, 1);
      check("step1_cnt", cycle_cnt, cexp(1));
      press(10);
      count_ce(30, c, o);
      check("step2_ce", c, 1);
      check("step2_cnt", cycle_cnt, cexp(2));
      c = 0;
      for (int i = 0; i < 3; i++) begin
         wait_div(3'd1);
         btn_step = 1'b1;
         count_ce(2, c2, o2);
         c += c2;
         btn_step = 1'b0;
         count_ce(12, c2, o2);
         c += c2;
      end
      count_ce(20, c2, o2);
      c += c2;
      check("glitch_ce", c, 0);
      check("glitch_halted", halted, 1);
      check("glitch_cnt", cycle_cnt, cexp(2));
      do_reset;
      wait_div(3'd1);
      btn_step = 1'b1;
      wait_sig("rst_step_entered", 1, 1'b0, 20);
      btn_step = 1'b0;
      wait_div(3'd5);
      check("rst_pre_tick_step", halted, 0);
      rst = 1'b0;
      #1;
      check("rst_ce", cpu_ce, 0);
      check("rst_halted", halted, 1);
      check("rst_cnt", cycle_cnt, 0);
      count_ce(8, c, o);
      check("rst_hold_ce", c, 0);
      rst = 1'b1;
      count_ce(20, c, o);
      check("rst_after_ce", c, 0);
      check("rst_after_halted", halted, 1);
      check("rst_after_cnt", cycle_cnt, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end
endmodule
